// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
//
// Memory-access controller that sits between the EX stage outputs and the
// MEM pipeline register.  Non-memory instructions flow straight through in
// the same cycle.  Loads and stores are turned into a single req/ack
// transaction on the data-memory bus.  Byte strobes and lane-replicated
// store data are produced here, and load data is sign/zero-extended here.
// The pipeline is frozen with stall until the access has completed.
//
// Parameters:
//   TIMEOUT      cycles allowed in REQ without dmemAck before the access is
//                abandoned and fault is raised (1..255)
//
// Optional build macro:
//   MISALIGN_TRAP_EN  when defined, misaligned half/word accesses never
//                     reach the bus and raise fault instead.  When it is
//                     undefined, the offending low address bits are cleared
//                     and the access proceeds normally.
//
// Ports:
//   Clock, Reset        core clock, synchronous active-high reset
//   exValid             EX presents a valid instruction
//   exRd, exResult      destination register, ALU result / effective address
//   exStoreData         rs2 value for stores
//   exWreg              instruction writes rd
//   exMemRead/Write     load / store (never both)
//   exFunct3            RV32I load/store width code
//   dmemReq, dmemWe     bus request and write select
//   dmemAddr, dmemBe    word address (bits[1:0]=0) and byte enables
//   dmemWdata           lane-replicated store data
//   dmemAck, dmemRdata  single-cycle completion strobe and read data
//   rd, result, Wreg    values presented to the MEM register
//   stall               freezes PC/IF/ID/EX
//   fault               one-cycle pulse: illegal funct3, timeout, misalign
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        exValid,
    input  logic [4:0]  exRd,
    input  logic [31:0] exResult,
    input  logic [31:0] exStoreData,
    input  logic        exWreg,
    input  logic        exMemRead,
    input  logic        exMemWrite,
    input  logic [2:0]  exFunct3,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [3:0]  dmemBe,
    output logic [31:0] dmemWdata,
    input  logic        dmemAck,
    input  logic [31:0] dmemRdata,
    output logic [4:0]  rd,
    output logic [31:0] result,
    output logic        Wreg,
    output logic        stall,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // The counter holds the number of REQ cycles already spent; the access
    // is abandoned in the REQ cycle where it reads TIMEOUT-1.
    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  count;

    logic [4:0]  lat_rd;
    logic        lat_wreg;
    logic [2:0]  lat_f3;
    logic [31:0] lat_addr;
    logic [1:0]  lat_off;
    logic        lat_we;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic        lat_fault;
    logic [31:0] lat_rdata;

    logic        start;
    logic        f3_legal;
    logic        misaligned;
    logic        entry_fault;
    logic [1:0]  off_eff;
    logic [3:0]  be_entry;
    logic [31:0] wdata_entry;

    // Pick the addressed byte or half out of the read word and extend it
    // according to the load width code.
    function automatic logic [31:0] format_load(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] data
    );
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        logic [31:0] formatted;
        sel_byte = data[{off, 3'b000} +: 8];
        sel_half = off[1] ? data[31:16] : data[15:0];
        case (f3)
            3'b000:  formatted = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  formatted = {24'd0, sel_byte};
            3'b001:  formatted = {{16{sel_half[15]}}, sel_half};
            3'b101:  formatted = {16'd0, sel_half};
            default: formatted = data;
        endcase
        return formatted;
    endfunction

    assign start = exValid & (exMemRead | exMemWrite);

    // Decode legality, alignment, strobes and store lanes of the instruction
    // currently in EX.  Only consumed in IDLE when a memory op is accepted.
    always_comb begin
        f3_legal    = 1'b0;
        misaligned  = 1'b0;
        entry_fault = 1'b0;
        off_eff     = exResult[1:0];
        be_entry    = 4'b1111;
        wdata_entry = exStoreData;

        if (exMemWrite) begin
            f3_legal = (exFunct3 == 3'b000) || (exFunct3 == 3'b001) ||
                       (exFunct3 == 3'b010);
        end else begin
            f3_legal = (exFunct3 == 3'b000) || (exFunct3 == 3'b001) ||
                       (exFunct3 == 3'b010) || (exFunct3 == 3'b100) ||
                       (exFunct3 == 3'b101);
        end

        misaligned = ((exFunct3[1:0] == 2'b01) && exResult[0]) ||
                     ((exFunct3[1:0] == 2'b10) && (exResult[1:0] != 2'b00));

`ifdef MISALIGN_TRAP_EN
        entry_fault = !f3_legal || misaligned;
        off_eff     = exResult[1:0];
`else
        entry_fault = !f3_legal;
        case (exFunct3[1:0])
            2'b01:   off_eff = {exResult[1], 1'b0};
            2'b10:   off_eff = 2'b00;
            default: off_eff = exResult[1:0];
        endcase
`endif

        if (exMemWrite) begin
            case (exFunct3[1:0])
                2'b00: begin
                    be_entry    = 4'b0001 << off_eff;
                    wdata_entry = {4{exStoreData[7:0]}};
                end
                2'b01: begin
                    be_entry    = 4'b0011 << off_eff;
                    wdata_entry = {2{exStoreData[15:0]}};
                end
                default: begin
                    be_entry    = 4'b1111;
                    wdata_entry = exStoreData;
                end
            endcase
        end
    end

    // State, timeout counter and the fields captured when an access starts.
    // Read data is captured on ack; a missing ack turns into a latched fault.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            lat_rd    <= '0;
            lat_wreg  <= 1'b0;
            lat_f3    <= '0;
            lat_addr  <= '0;
            lat_off   <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_wdata <= '0;
            lat_fault <= 1'b0;
            lat_rdata <= '0;
        end else begin
            state <= state_next;

            if (state == REQ) begin
                count <= count + 8'd1;
            end else begin
                count <= '0;
            end

            if ((state == IDLE) && start) begin
                lat_rd    <= exRd;
                lat_wreg  <= exWreg;
                lat_f3    <= exFunct3;
                lat_addr  <= exResult;
                lat_off   <= off_eff;
                lat_we    <= exMemWrite;
                lat_be    <= exMemWrite ? be_entry : 4'b1111;
                lat_wdata <= wdata_entry;
                lat_fault <= entry_fault;
                lat_rdata <= '0;
            end

            if (state == REQ) begin
                if (dmemAck) begin
                    lat_rdata <= format_load(lat_f3, lat_off, dmemRdata);
                end else if (count == COUNT_LAST) begin
                    lat_fault <= 1'b1;
                end
            end
        end
    end

    // Next state and pipeline-side outputs.  Defaults describe the IDLE
    // pass-through case; memory states override with a bubble or the
    // completed result.  An ack that coincides with the timeout wins.
    always_comb begin
        state_next = state;
        rd         = exRd;
        result     = exResult;
        Wreg       = exWreg & exValid;
        stall      = 1'b0;
        dmemReq    = 1'b0;
        fault      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    rd         = '0;
                    result     = '0;
                    Wreg       = 1'b0;
                    stall      = 1'b1;
                    state_next = entry_fault ? RESP : REQ;
                end
            end
            REQ: begin
                rd      = '0;
                result  = '0;
                Wreg    = 1'b0;
                stall   = 1'b1;
                dmemReq = 1'b1;
                if (dmemAck || (count == COUNT_LAST)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rd         = lat_rd;
                Wreg       = lat_wreg & !lat_fault;
                result     = lat_we ? lat_addr : lat_rdata;
                fault      = lat_fault;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus fields come straight from the latched copies so they stay stable
    // for the whole request.
    assign dmemWe    = lat_we;
    assign dmemAddr  = {lat_addr[31:2], 2'b00};
    assign dmemBe    = lat_be;
    assign dmemWdata = lat_wdata;

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
//
// Self-checking bench for mem_access.  A table of pass-through vectors and a
// table of single memory transactions are applied first, followed by
// hand-written multi-cycle sequences (timeout, misalignment, reset during a
// request, stray ack) and a randomized run checked against a reference
// model that works from the load/store rules with plain arithmetic.
// Honours MISALIGN_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mem_access;

    localparam int TO = 16;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        exValid;
    logic [4:0]  exRd;
    logic [31:0] exResult;
    logic [31:0] exStoreData;
    logic        exWreg;
    logic        exMemRead;
    logic        exMemWrite;
    logic [2:0]  exFunct3;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [3:0]  dmemBe;
    logic [31:0] dmemWdata;
    logic        dmemAck;
    logic [31:0] dmemRdata;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        Wreg;
    logic        stall;
    logic        fault;

    int compared   = 0;
    int mismatched = 0;

    mem_access #(.TIMEOUT(TO)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .exValid     (exValid),
        .exRd        (exRd),
        .exResult    (exResult),
        .exStoreData (exStoreData),
        .exWreg      (exWreg),
        .exMemRead   (exMemRead),
        .exMemWrite  (exMemWrite),
        .exFunct3    (exFunct3),
        .dmemReq     (dmemReq),
        .dmemWe      (dmemWe),
        .dmemAddr    (dmemAddr),
        .dmemBe      (dmemBe),
        .dmemWdata   (dmemWdata),
        .dmemAck     (dmemAck),
        .dmemRdata   (dmemRdata),
        .rd          (rd),
        .result      (result),
        .Wreg        (Wreg),
        .stall       (stall),
        .fault       (fault)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] result;
        bit          fault;
        bit          bus;
    } model_t;

    typedef struct {
        bit          finished;
        int          stallCycles;
        int          reqCycles;
        bit          stable;
        bit          earlyFault;
        bit          earlyWreg;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        wreg;
        logic        fault;
        logic        postFault;
        logic        postStall;
    } obs_t;

    typedef struct {
        logic        valid;
        logic        memRead;
        logic [4:0]  rdIn;
        logic [31:0] resIn;
        logic        wregIn;
        logic [4:0]  expRd;
        logic [31:0] expRes;
        logic        expWreg;
    } pt_vec_t;

    typedef struct {
        bit          isStore;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        wregIn;
        int          ackDelay;
        int          expReq;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expResult;
        logic        expWreg;
        logic        expFault;
    } mem_vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference behaviour derived from the access width and byte offset.
    function automatic model_t refModel(input bit isStore, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] sd,
                                        input logic [31:0] rdat);
        model_t m;
        int fc;
        int width;
        int off;
        bit legal;
        bit mis;
        logic [31:0] v;
        fc = int'(f3);
        if (isStore) legal = (fc <= 2);
        else         legal = (fc == 0) || (fc == 1) || (fc == 2) || (fc == 4) || (fc == 5);
        width = ((fc % 4) == 0) ? 1 : ((fc % 4) == 1) ? 2 : 4;
        off   = int'(a % 32'd4);
        mis   = (off % width) != 0;
        m.fault = !legal;
`ifdef MISALIGN_TRAP_EN
        if (mis) m.fault = 1'b1;
`else
        if (mis) off = off - (off % width);
`endif
        m.bus  = !m.fault;
        m.addr = a - (a % 32'd4);
        if (isStore) begin
            m.be     = 4'(((1 << width) - 1) << off);
            if (width == 1)      m.wdata = (sd & 32'd255) * 32'h0101_0101;
            else if (width == 2) m.wdata = (sd & 32'd65535) * 32'h0001_0001;
            else                 m.wdata = sd;
            m.result = a;
        end else begin
            m.be    = 4'hF;
            m.wdata = 32'd0;
            v = rdat >> (8 * off);
            if (width == 1) begin
                v = v & 32'd255;
                if (fc == 0 && v >= 32'd128) v = v - 32'd256;
            end else if (width == 2) begin
                v = v & 32'd65535;
                if (fc == 1 && v >= 32'd32768) v = v - 32'd65536;
            end
            m.result = v;
        end
        return m;
    endfunction

    // Presents one memory op, answers the bus after ackDelay REQ cycles
    // (negative: never) and records what the DUT did until its RESP cycle.
    task automatic applyStimulus(input bit isStore, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rdat, input logic [4:0] rdIn,
                                 input logic wregIn, input int ackDelay,
                                 output obs_t o);
        int cyc;
        o = '{default: 0};
        o.stable = 1'b1;
        cyc = 0;
        while (!o.finished && cyc < 300) begin
            @(negedge Clock);
            if (cyc == 0) begin
                exValid     = 1'b1;
                exRd        = rdIn;
                exResult    = a;
                exStoreData = sd;
                exWreg      = wregIn;
                exMemRead   = !isStore;
                exMemWrite  = isStore;
                exFunct3    = f3;
            end
            if (dmemReq && o.reqCycles == ackDelay) begin
                dmemAck   = 1'b1;
                dmemRdata = rdat;
            end else begin
                dmemAck   = 1'b0;
                dmemRdata = $urandom;
            end
            #1;
            if (dmemReq) begin
                if (o.reqCycles == 0) begin
                    o.addr  = dmemAddr;
                    o.be    = dmemBe;
                    o.we    = dmemWe;
                    o.wdata = dmemWdata;
                end else if (dmemAddr !== o.addr || dmemBe !== o.be ||
                             dmemWe !== o.we || dmemWdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
                o.reqCycles++;
            end
            if (stall) begin
                o.stallCycles++;
                if (fault) o.earlyFault = 1'b1;
                if (Wreg)  o.earlyWreg  = 1'b1;
            end else begin
                o.rd       = rd;
                o.result   = result;
                o.wreg     = Wreg;
                o.fault    = fault;
                o.finished = 1'b1;
            end
            cyc++;
        end
        @(negedge Clock);
        exValid    = 1'b0;
        exMemRead  = 1'b0;
        exMemWrite = 1'b0;
        dmemAck    = 1'b0;
        #1;
        o.postFault = fault;
        o.postStall = stall;
    endtask

    // Runs one op and checks it against the reference model.
    task automatic runAndCheck(input string tag, input bit isStore, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic [31:0] rdat, input logic [4:0] rdIn,
                               input logic wregIn, input int ackDelay);
        model_t m;
        obs_t   o;
        int     expReq;
        bit     acked;
        bit     expFault;
        m = refModel(isStore, f3, a, sd, rdat);
        applyStimulus(isStore, f3, a, sd, rdat, rdIn, wregIn, ackDelay, o);
        acked    = (ackDelay >= 0) && (ackDelay < TO);
        expReq   = !m.bus ? 0 : (acked ? ackDelay + 1 : TO);
        expFault = m.fault || (m.bus && !acked);
        checkOutput({tag, " done"}, 32'(o.finished), 32'd1);
        checkOutput({tag, " reqCycles"}, 32'(o.reqCycles), 32'(expReq));
        checkOutput({tag, " stallCycles"}, 32'(o.stallCycles), 32'(expReq + 1));
        checkOutput({tag, " fault"}, 32'(o.fault), 32'(expFault));
        checkOutput({tag, " Wreg"}, 32'(o.wreg), 32'(wregIn & !expFault));
        checkOutput({tag, " rd"}, 32'(o.rd), 32'(rdIn));
        checkOutput({tag, " earlyFault/Wreg"}, 32'({o.earlyFault, o.earlyWreg}), 32'd0);
        checkOutput({tag, " post fault/stall"}, 32'({o.postFault, o.postStall}), 32'd0);
        if (m.bus) begin
            checkOutput({tag, " dmemAddr"}, o.addr, m.addr);
            checkOutput({tag, " dmemBe"}, 32'(o.be), 32'(m.be));
            checkOutput({tag, " dmemWe"}, 32'(o.we), 32'(isStore));
            checkOutput({tag, " bus stable"}, 32'(o.stable), 32'd1);
            if (isStore) checkOutput({tag, " dmemWdata"}, o.wdata, m.wdata);
        end
        if (!expFault) checkOutput({tag, " result"}, o.result, m.result);
    endtask

    pt_vec_t  ptVec[5];
    mem_vec_t memVec[10];

    initial begin
        obs_t o;
        pt_vec_t p;
        mem_vec_t mv;

        ptVec[0] = '{1'b1, 1'b0, 5'd5,  32'h0000_1234, 1'b1, 5'd5,  32'h0000_1234, 1'b1};
        ptVec[1] = '{1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd31, 32'hFFFF_FFFF, 1'b0};
        ptVec[2] = '{1'b0, 1'b0, 5'd7,  32'h0000_DEAD, 1'b1, 5'd7,  32'h0000_DEAD, 1'b0};
        ptVec[3] = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd0,  32'h0000_0000, 1'b1};
        ptVec[4] = '{1'b0, 1'b1, 5'd9,  32'h0000_0104, 1'b1, 5'd9,  32'h0000_0104, 1'b0};

        //            st    f3      addr          sdata         rdata         wr  ack req expAddr       be       wdata         result        Wr    F
        memVec[0] = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 1'b1, 0, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b0};
        memVec[1] = '{1'b1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0,        1'b0, 3, 4, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0202, 1'b0, 1'b0};
        memVec[2] = '{1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h1234_8056, 1'b1, 1, 2, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0080, 1'b1, 1'b0};
        memVec[3] = '{1'b0, 3'b101, 32'h0000_0302, 32'h0,        32'hF00D_1234, 1'b1, 0, 1, 32'h0000_0300, 4'b1111, 32'h0,        32'h0000_F00D, 1'b1, 1'b0};
        memVec[4] = '{1'b0, 3'b001, 32'h0000_0300, 32'h0,        32'h0000_8001, 1'b1, 2, 3, 32'h0000_0300, 4'b1111, 32'h0,        32'hFFFF_8001, 1'b1, 1'b0};
        memVec[5] = '{1'b1, 3'b000, 32'h0000_0043, 32'h1234_5678, 32'h0,        1'b0, 0, 1, 32'h0000_0040, 4'b1000, 32'h7878_7878, 32'h0000_0043, 1'b0, 1'b0};
        memVec[6] = '{1'b1, 3'b010, 32'h0000_0050, 32'hCAFE_F00D, 32'h0,        1'b0, 1, 2, 32'h0000_0050, 4'b1111, 32'hCAFE_F00D, 32'h0000_0050, 1'b0, 1'b0};
        memVec[7] = '{1'b0, 3'b010, 32'h0000_0060, 32'h0,        32'h1357_9BDF, 1'b1, 0, 1, 32'h0000_0060, 4'b1111, 32'h0,        32'h1357_9BDF, 1'b1, 1'b0};
        memVec[8] = '{1'b0, 3'b011, 32'h0000_0070, 32'h0,        32'h0,        1'b1, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 1'b1};
        memVec[9] = '{1'b1, 3'b100, 32'h0000_0074, 32'h5555_5555, 32'h0,        1'b0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 1'b1};

        Reset = 1'b1;
        exValid = 1'b0; exRd = '0; exResult = '0; exStoreData = '0; exWreg = 1'b0;
        exMemRead = 1'b0; exMemWrite = 1'b0; exFunct3 = '0;
        dmemAck = 1'b0; dmemRdata = '0;

        repeat (2) @(negedge Clock);
        #1;
        checkOutput("reset dmemReq", 32'(dmemReq), 32'd0);
        checkOutput("reset fault", 32'(fault), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset Wreg", 32'(Wreg), 32'd0);
        Reset = 1'b0;

        $display("[TB] pass-through vectors");
        for (int i = 0; i < 5; i++) begin
            p = ptVec[i];
            @(negedge Clock);
            exValid = p.valid; exMemRead = p.memRead; exMemWrite = 1'b0;
            exRd = p.rdIn; exResult = p.resIn; exWreg = p.wregIn; exFunct3 = 3'b010;
            #1;
            checkOutput($sformatf("pt%0d rd", i), 32'(rd), 32'(p.expRd));
            checkOutput($sformatf("pt%0d result", i), result, p.expRes);
            checkOutput($sformatf("pt%0d Wreg", i), 32'(Wreg), 32'(p.expWreg));
            checkOutput($sformatf("pt%0d stall/req", i), 32'({stall, dmemReq}), 32'd0);
        end
        @(negedge Clock);
        exValid = 1'b0; exMemRead = 1'b0;

        $display("[TB] memory transaction vectors");
        for (int i = 0; i < 10; i++) begin
            mv = memVec[i];
            applyStimulus(mv.isStore, mv.f3, mv.addr, mv.sdata, mv.rdata, 5'(i + 3),
                          mv.wregIn, mv.ackDelay, o);
            checkOutput($sformatf("vec%0d done", i), 32'(o.finished), 32'd1);
            checkOutput($sformatf("vec%0d reqCycles", i), 32'(o.reqCycles), 32'(mv.expReq));
            checkOutput($sformatf("vec%0d stallCycles", i), 32'(o.stallCycles), 32'(mv.expReq + 1));
            checkOutput($sformatf("vec%0d fault", i), 32'(o.fault), 32'(mv.expFault));
            checkOutput($sformatf("vec%0d Wreg", i), 32'(o.wreg), 32'(mv.expWreg));
            checkOutput($sformatf("vec%0d rd", i), 32'(o.rd), 32'(i + 3));
            if (!mv.expFault) begin
                checkOutput($sformatf("vec%0d dmemAddr", i), o.addr, mv.expAddr);
                checkOutput($sformatf("vec%0d dmemBe", i), 32'(o.be), 32'(mv.expBe));
                checkOutput($sformatf("vec%0d dmemWe", i), 32'(o.we), 32'(mv.isStore));
                checkOutput($sformatf("vec%0d result", i), o.result, mv.expResult);
                checkOutput($sformatf("vec%0d bus stable", i), 32'(o.stable), 32'd1);
                if (mv.isStore) checkOutput($sformatf("vec%0d dmemWdata", i), o.wdata, mv.expWdata);
            end
        end

        $display("[TB] timeout sequence");
        applyStimulus(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 5'd12, 1'b1, -1, o);
        checkOutput("timeout reqCycles", 32'(o.reqCycles), 32'(TO));
        checkOutput("timeout stallCycles", 32'(o.stallCycles), 32'(TO + 1));
        checkOutput("timeout fault", 32'(o.fault), 32'd1);
        checkOutput("timeout Wreg", 32'(o.wreg), 32'd0);
        checkOutput("timeout back idle", 32'({o.postFault, o.postStall}), 32'd0);

        $display("[TB] misaligned LW sequence");
        applyStimulus(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h1122_3344, 5'd14, 1'b1, 0, o);
`ifdef MISALIGN_TRAP_EN
        checkOutput("misalign reqCycles", 32'(o.reqCycles), 32'd0);
        checkOutput("misalign stallCycles", 32'(o.stallCycles), 32'd1);
        checkOutput("misalign fault", 32'(o.fault), 32'd1);
        checkOutput("misalign Wreg", 32'(o.wreg), 32'd0);
`else
        checkOutput("misalign reqCycles", 32'(o.reqCycles), 32'd1);
        checkOutput("misalign dmemAddr", o.addr, 32'h0000_0004);
        checkOutput("misalign fault", 32'(o.fault), 32'd0);
        checkOutput("misalign result", o.result, 32'h1122_3344);
        checkOutput("misalign Wreg", 32'(o.wreg), 32'd1);
`endif

        $display("[TB] reset during request");
        @(negedge Clock);
        exValid = 1'b1; exMemRead = 1'b1; exMemWrite = 1'b0; exFunct3 = 3'b010;
        exResult = 32'h0000_0080; exRd = 5'd6; exWreg = 1'b1; dmemAck = 1'b0;
        @(negedge Clock);
        #1 checkOutput("rst req cycle1", 32'(dmemReq), 32'd1);
        @(negedge Clock);
        Reset = 1'b1;
        #1 checkOutput("rst req cycle2", 32'(dmemReq), 32'd1);
        @(negedge Clock);
        Reset = 1'b0; exValid = 1'b0; exMemRead = 1'b0;
        dmemAck = 1'b1; dmemRdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("rst after req", 32'(dmemReq), 32'd0);
        checkOutput("rst after Wreg/fault/stall", 32'({Wreg, fault, stall}), 32'd0);
        @(negedge Clock);
        dmemAck = 1'b0;
        #1;
        checkOutput("rst later req", 32'(dmemReq), 32'd0);
        checkOutput("rst later Wreg/fault/stall", 32'({Wreg, fault, stall}), 32'd0);
        @(negedge Clock);
        exValid = 1'b1; exRd = 5'd21; exResult = 32'h0BAD_F00D; exWreg = 1'b1;
        #1;
        checkOutput("rst idle rd", 32'(rd), 32'd21);
        checkOutput("rst idle result", result, 32'h0BAD_F00D);

        $display("[TB] stray ack in IDLE");
        @(negedge Clock);
        exRd = 5'd2; exResult = 32'h0000_0055; dmemAck = 1'b1;
        #1;
        checkOutput("stray ack stall/req", 32'({stall, dmemReq}), 32'd0);
        checkOutput("stray ack result", result, 32'h0000_0055);
        @(negedge Clock);
        dmemAck = 1'b0; exValid = 1'b0;
        #1;
        checkOutput("stray ack after", 32'({stall, dmemReq, fault}), 32'd0);

        $display("[TB] randomized run");
        for (int n = 0; n < 40; n++) begin
            int kind;
            int ackDelay;
            logic [2:0] f3;
            logic [31:0] a;
            logic [4:0] r;
            logic w;
            kind = int'($urandom_range(0, 3));
            a = $urandom;
            r = 5'($urandom_range(0, 31));
            w = 1'($urandom_range(0, 1));
            ackDelay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            if (kind == 0) begin
                @(negedge Clock);
                exValid = w; exMemRead = 1'b0; exMemWrite = 1'b0;
                exRd = r; exResult = a; exWreg = 1'b1;
                #1;
                checkOutput($sformatf("rnd%0d alu rd", n), 32'(rd), 32'(r));
                checkOutput($sformatf("rnd%0d alu result", n), result, a);
                checkOutput($sformatf("rnd%0d alu Wreg", n), 32'(Wreg), 32'(w));
                checkOutput($sformatf("rnd%0d alu stall", n), 32'({stall, dmemReq}), 32'd0);
            end else if (kind == 3) begin
                f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                runAndCheck($sformatf("rnd%0d st", n), 1'b1, f3, a, $urandom, 32'h0, r, w, ackDelay);
            end else begin
                f3 = 3'($urandom_range(0, 7));
                runAndCheck($sformatf("rnd%0d ld", n), 1'b0, f3, a, 32'h0, $urandom, r, w, ackDelay);
            end
        end
        @(negedge Clock);
        exValid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
